// File: rtl/out_uart_pkg.sv
// Shared types and defaults for the CPU output UART transmitter.
package out_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned FIFO_DEPTH_DEFAULT   = 4;
    localparam int unsigned WORD_W               = 16;
    localparam int unsigned BYTE_W               = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/out_fifo.sv
// Word FIFO buffering CPU output words ahead of the serialiser.
module out_fifo
    import out_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned WIDTH      = WORD_W
) (
    input  logic             i_clk,
    input  logic             i_nReset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // A write while full is dropped even if a pop happens on the same edge.
    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    // Next occupancy; push+pop together leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage array, cleared on reset.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/out_uart_tx.sv
// Serialises buffered 16-bit CPU words as two 8N1 bytes, high byte first.
module out_uart_tx
    import out_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_nReset,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_wrOut,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_busy,
    output logic              o_overflow,
    output logic              o_tx
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic              r_sel;
    logic [WORD_W-1:0] r_shift;
    logic              r_tx;
    logic              r_busy;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic [WORD_W-1:0] w_rd_data;
    logic              w_pop;
    logic              w_bit_end;
    logic [BYTE_W-1:0] w_byte;

    out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (WORD_W)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_nReset (i_nReset),
        .i_push   (i_wrOut),
        .i_pop    (w_pop),
        .i_data   (i_data),
        .o_data   (w_rd_data),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_byte    = r_sel ? r_shift[7:0] : r_shift[15:8];

    // Pop when idle, or at the end of a low-byte stop bit for gapless frames.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            IDLE:    w_pop = !w_empty;
            STOP:    w_pop = w_bit_end && r_sel && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    // Sticky overflow on any write presented while the FIFO is full.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_overflow <= 1'b0;
        end else if (i_wrOut && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Frame FSM with baud counter that restarts at every bit boundary.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_sel   <= 1'b0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift <= w_rd_data;
                        r_sel   <= 1'b0;
                        r_baud  <= '0;
                        r_state <= START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= DATA;
                        r_tx    <= w_byte[0];
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= w_byte[r_bit + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (!r_sel) begin
                            r_sel   <= 1'b1;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else if (!w_empty) begin
                            r_shift <= w_rd_data;
                            r_sel   <= 1'b0;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_busy     = r_busy;
    assign o_overflow = r_overflow;
    assign o_tx       = r_tx;

endmodule

// File: tb/tb_out_uart_tx.sv
// Self-checking bench for out_uart_tx with a word-level line model.
module tb_out_uart_tx;

    localparam int unsigned CPB      = 4;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned WORD_CYC = 20 * CPB;

    logic        i_clk    = 1'b0;
    logic        i_nReset = 1'b1;
    logic        i_wrOut  = 1'b0;
    logic [15:0] i_data   = 16'h0000;
    logic        o_full;
    logic        o_empty;
    logic        o_busy;
    logic        o_overflow;
    logic        o_tx;

    int errors = 0;
    int checks = 0;

    // Reference model state: queued words, current word and its start edge.
    logic [15:0] m_q[$];
    logic [15:0] m_cur      = 16'h0000;
    int          m_e        = 0;
    int          m_next_free = 0;
    int          m_start    = 0;
    bit          m_busy     = 1'b0;
    bit          m_ovf      = 1'b0;
    bit          m_tx       = 1'b1;
    bit          mon_en     = 1'b0;

    always #5 i_clk = ~i_clk;

    out_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_nReset   (i_nReset),
        .i_data     (i_data),
        .i_wrOut    (i_wrOut),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_tx       (o_tx)
    );

    // Expected line level t cycles into a word: 2 frames of start, 8 data LSB first, stop.
    function automatic bit line_bit(input logic [15:0] w, input int t);
        int         b;
        int         pos;
        logic [7:0] by;
        b   = t / CPB;
        pos = b % 10;
        by  = (b < 10) ? w[15:8] : w[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos-1];
    endfunction

    // Model: a word starts when the line is free and a word was queued before the edge.
    initial forever begin
        int  pre;
        bit  pop;
        @(posedge i_clk);
        if (!i_nReset) begin
            m_q.delete();
            m_e = 0; m_next_free = 0; m_start = 0; m_cur = 16'h0000;
            m_busy = 1'b0; m_ovf = 1'b0; m_tx = 1'b1;
        end else begin
            m_e++;
            pre = m_q.size();
            pop = (m_e >= m_next_free) && (pre > 0);
            if (i_wrOut) begin
                if (pre < int'(DEPTH)) m_q.push_back(i_data);
                else m_ovf = 1'b1;
            end
            if (pop) begin
                m_cur       = m_q.pop_front();
                m_start     = m_e;
                m_next_free = m_e + int'(WORD_CYC);
            end
            m_busy = (m_e < m_next_free);
            m_tx   = m_busy ? line_bit(m_cur, m_e - m_start) : 1'b1;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial forever begin
        @(negedge i_clk);
        if (mon_en) begin
            checks += 5;
            if (o_tx !== m_tx) begin
                errors++; $display("FAIL mon_tx at %0t got=%b exp=%b", $time, o_tx, m_tx);
            end
            if (o_busy !== m_busy) begin
                errors++; $display("FAIL mon_busy at %0t got=%b exp=%b", $time, o_busy, m_busy);
            end
            if (o_full !== (m_q.size() == int'(DEPTH))) begin
                errors++; $display("FAIL mon_full at %0t got=%b exp=%b", $time, o_full, m_q.size() == int'(DEPTH));
            end
            if (o_empty !== (m_q.size() == 0)) begin
                errors++; $display("FAIL mon_empty at %0t got=%b exp=%b", $time, o_empty, m_q.size() == 0);
            end
            if (o_overflow !== m_ovf) begin
                errors++; $display("FAIL mon_overflow at %0t got=%b exp=%b", $time, o_overflow, m_ovf);
            end
        end
    end

    task automatic reset_dut();
        @(negedge i_clk);
        #1;
        mon_en   = 1'b0;
        i_wrOut  = 1'b0;
        i_nReset = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        i_nReset = 1'b1;
        mon_en   = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_busy) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (m_q.size() != 0 || m_busy) begin
            errors++; $display("FAIL drain_timeout got=%0d cycles exp<%0d", n, budget);
        end
    endtask

    task automatic test_reset();
        #2 i_nReset = 1'b0;
        #1;
        checks += 5;
        if (o_tx !== 1'b1)       begin errors++; $display("FAIL rst_tx got=%b exp=1", o_tx); end
        if (o_full !== 1'b0)     begin errors++; $display("FAIL rst_full got=%b exp=0", o_full); end
        if (o_empty !== 1'b1)    begin errors++; $display("FAIL rst_empty got=%b exp=1", o_empty); end
        if (o_busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", o_overflow); end
        repeat (2) @(negedge i_clk);
        #1;
        i_nReset = 1'b1;
        mon_en   = 1'b1;
    endtask

    task automatic test_single();
        bit         line[200];
        int         nb;
        logic [7:0] rx_hi;
        logic [7:0] rx_lo;
        @(negedge i_clk);
        i_wrOut = 1'b1; i_data = 16'hA55A;
        @(negedge i_clk);
        i_wrOut = 1'b0;
        checks++;
        if (o_tx !== 1'b1) begin errors++; $display("FAIL single_tx_at_write got=%b exp=1", o_tx); end
        @(negedge i_clk);
        checks++;
        if (o_tx !== 1'b0) begin errors++; $display("FAIL single_latency got=%b exp=0", o_tx); end
        line[0] = o_tx;
        nb = 1;
        for (int i = 1; i < 200; i++) begin
            @(negedge i_clk);
            if (!o_busy) break;
            line[i] = o_tx;
            nb++;
        end
        checks += 2;
        if (nb != int'(WORD_CYC)) begin errors++; $display("FAIL single_len got=%0d exp=%0d", nb, WORD_CYC); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", o_empty); end
        for (int j = 0; j < 8; j++) begin
            rx_hi[j] = line[CPB*(1+j) + CPB/2];
            rx_lo[j] = line[CPB*(11+j) + CPB/2];
        end
        checks += 4;
        if (rx_hi !== 8'hA5) begin errors++; $display("FAIL single_hi got=%h exp=a5", rx_hi); end
        if (rx_lo !== 8'h5A) begin errors++; $display("FAIL single_lo got=%h exp=5a", rx_lo); end
        if (line[CPB*9 + CPB/2] !== 1'b1)  begin errors++; $display("FAIL single_stop1 got=0 exp=1"); end
        if (line[CPB*10 + CPB/2] !== 1'b0) begin errors++; $display("FAIL single_start2 got=1 exp=0"); end
    endtask

    task automatic test_back_to_back();
        int nb;
        reset_dut();
        nb = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge i_clk);
            if (cyc == 5) begin
                checks += 2;
                if (o_full !== 1'b1)     begin errors++; $display("FAIL b2b_full got=%b exp=1", o_full); end
                if (o_overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_ovf got=%b exp=0", o_overflow); end
            end
            if (cyc == 6) begin
                checks++;
                if (o_overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf got=%b exp=1", o_overflow); end
            end
            if (o_busy) nb++;
            else if (cyc > 6) break;
            i_wrOut = (cyc < 6);
            i_data  = 16'(cyc + 1);
        end
        i_wrOut = 1'b0;
        checks += 2;
        if (nb != 5 * int'(WORD_CYC)) begin errors++; $display("FAIL b2b_contiguous got=%0d exp=%0d", nb, 5 * WORD_CYC); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", o_empty); end
    endtask

    task automatic test_full_pop();
        int n;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            i_wrOut = 1'b1; i_data = 16'h1100 + 16'(i);
        end
        @(negedge i_clk);
        i_wrOut = 1'b0;
        n = 0;
        while (m_e + 1 != m_next_free && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        checks += 3;
        if (n >= 200) begin errors++; $display("FAIL fullpop_wait got=%0d exp<200", n); end
        if (o_full !== 1'b1)     begin errors++; $display("FAIL fullpop_pre_full got=%b exp=1", o_full); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL fullpop_pre_ovf got=%b exp=0", o_overflow); end
        i_wrOut = 1'b1; i_data = 16'hBEEF;
        @(negedge i_clk);
        i_wrOut = 1'b0;
        checks += 3;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL fullpop_ovf got=%b exp=1", o_overflow); end
        if (o_full !== 1'b0)     begin errors++; $display("FAIL fullpop_full got=%b exp=0", o_full); end
        if (o_empty !== 1'b0)    begin errors++; $display("FAIL fullpop_empty got=%b exp=0", o_empty); end
        wait_drain(600);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL fullpop_idle got=%b exp=0", o_busy); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int tr;
        bit prev;
        reset_dut();
        @(negedge i_clk);
        i_wrOut = 1'b1; i_data = 16'h1234;
        @(negedge i_clk);
        i_wrOut = 1'b0;
        n = 0;
        while (!(m_busy && (m_e - m_start) == int'(4*CPB + 1)) && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_tx !== 1'b0) begin errors++; $display("FAIL midrst_bit3 got=%b exp=0", o_tx); end
        #1;
        mon_en   = 1'b0;
        i_nReset = 1'b0;
        #1;
        checks += 4;
        if (o_tx !== 1'b1)    begin errors++; $display("FAIL midrst_tx got=%b exp=1", o_tx); end
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got=%b exp=1", o_empty); end
        if (o_full !== 1'b0)  begin errors++; $display("FAIL midrst_full got=%b exp=0", o_full); end
        repeat (2) @(negedge i_clk);
        #1;
        i_nReset = 1'b1;
        mon_en   = 1'b1;
        tr   = 0;
        prev = o_tx;
        for (int i = 0; i < 120; i++) begin
            @(negedge i_clk);
            if (o_tx !== prev) tr++;
            prev = o_tx;
        end
        checks += 3;
        if (tr != 0)          begin errors++; $display("FAIL midrst_quiet got=%0d exp=0", tr); end
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL midrst_post_busy got=%b exp=0", o_busy); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL midrst_post_empty got=%b exp=1", o_empty); end
    endtask

    task automatic test_wrap();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            i_wrOut = 1'b1; i_data = 16'($urandom);
        end
        @(negedge i_clk);
        i_wrOut = 1'b0;
        wait_drain(500);
        @(negedge i_clk);
        i_wrOut = 1'b1; i_data = 16'hFFFF;
        @(negedge i_clk);
        i_data = 16'h0000;
        @(negedge i_clk);
        i_wrOut = 1'b0;
        wait_drain(300);
        checks += 2;
        if (o_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", o_empty); end
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL wrap_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            @(negedge i_clk);
            i_wrOut = ($urandom_range(0, 19) == 0);
            i_data  = 16'($urandom);
        end
        @(negedge i_clk);
        i_wrOut = 1'b0;
        wait_drain(900);
        checks += 3;
        if (o_empty !== 1'b1)    begin errors++; $display("FAIL rand_empty got=%b exp=1", o_empty); end
        if (o_busy !== 1'b0)     begin errors++; $display("FAIL rand_busy got=%b exp=0", o_busy); end
        if (o_overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf got=%b exp=%b", o_overflow, m_ovf); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_pop();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
